ov7670_sccb_init_sequencer: RTL and testbench

- Sequences OV7670 register configuration through the existing i2c_master AXI-stream command/data ports.
- Walks a register table held in an external synchronous ROM. Each entry is a register address and value pair, or a delay/end marker.
- Each entry becomes one SCCB write-multiple transaction.
- After the table completes, the block shares the same i2c_master with a single-register write requester driven by the HCI buttons and switches.

---
 rtl/ov7670_sccb_init_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_ov7670_sccb_init_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_sccb_init_sequencer.sv
// Purpose: walks an OV7670 register table in ROM and issues one SCCB write-multiple per entry, then serves user single-register writes.
// Latency: start to first cmd_valid is 3 cycles (FETCH, DECODE, CMD); delay markers add DELAY_CYCLES cycles.
// Backpressure: cmd_valid/data_tvalid hold with stable payload until cmd_ready/data_tready; usr_ready only pulses in READY.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 pulse: (re)start the table walk from entry 0 (honoured in IDLE/READY only)
//   rom_addr / rom_data   synchronous table ROM, data valid one cycle after address; entry = {reg, val}
//                         16'hFFFF = end of table, 16'hFFFE = delay marker
//   usr_valid/usr_ready   user write request {usr_reg, usr_val}, accepted only in READY
//   cmd_* / data_*        i2c_master AXI-stream command and write-data ports
//   i2c_busy              i2c_master busy, used to wait for the bus transaction to finish
//   busy, done, entry_cnt status: walking/transacting, table complete (sticky), entries written (saturating)
module ov7670_sccb_init_sequencer #(
    parameter logic [6:0] DEV_ADDR     = 7'h21,
    parameter int         ROM_AW       = 8,
    parameter int         DELAY_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic              usr_valid,
    input  logic [7:0]        usr_reg,
    input  logic [7:0]        usr_val,
    output logic              usr_ready,
    output logic [6:0]        cmd_address,
    output logic              cmd_start,
    output logic              cmd_read,
    output logic              cmd_write,
    output logic              cmd_write_multiple,
    output logic              cmd_stop,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [7:0]        data_tdata,
    output logic              data_tvalid,
    input  logic              data_tready,
    output logic              data_tlast,
    input  logic              i2c_busy,
    output logic              busy,
    output logic              done,
    output logic [7:0]        entry_cnt
);

    localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [DW-1:0] DELAY_LAST = DW'(DELAY_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, CMD, DREG, DVAL, DRAIN, DELAY,
        READY, UCMD, UDREG, UDVAL, UDRAIN
    } state_t;

    state_t        state, state_d;
    logic [7:0]    cur_reg, cur_val;
    logic [DW-1:0] delay_cnt;
    logic [3:0]    drain_cnt;
    logic          busy_seen;

    // Strobes from the next-state logic to the datapath registers.
    logic restart, latch_rom, latch_usr, addr_inc, cnt_inc, set_done;
    logic drain_ok;
    logic last_addr;

    // Bus transaction is finished once busy has been seen and dropped again;
    // if busy never rises within 16 DRAIN cycles, carry on regardless.
    assign drain_ok  = !i2c_busy && (busy_seen || (drain_cnt == 4'd15));
    // Advancing past the last ROM slot would wrap to 0: treat that as end of table.
    assign last_addr = (rom_addr == {ROM_AW{1'b1}});

    always_comb begin
        state_d     = state;
        restart     = 1'b0;
        latch_rom   = 1'b0;
        latch_usr   = 1'b0;
        addr_inc    = 1'b0;
        cnt_inc     = 1'b0;
        set_done    = 1'b0;
        usr_ready   = 1'b0;
        cmd_valid   = 1'b0;
        data_tvalid = 1'b0;
        data_tdata  = 8'h00;
        data_tlast  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    restart = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (rom_data == 16'hFFFF) begin
                    set_done = 1'b1;
                    state_d  = READY;
                end else if (rom_data == 16'hFFFE) begin
                    state_d = DELAY;
                end else begin
                    latch_rom = 1'b1;
                    state_d   = CMD;
                end
            end
            CMD, UCMD: begin
                cmd_valid = 1'b1;
                if (cmd_ready) state_d = (state == CMD) ? DREG : UDREG;
            end
            DREG, UDREG: begin
                data_tvalid = 1'b1;
                data_tdata  = cur_reg;
                if (data_tready) state_d = (state == DREG) ? DVAL : UDVAL;
            end
            DVAL, UDVAL: begin
                data_tvalid = 1'b1;
                data_tdata  = cur_val;
                data_tlast  = 1'b1;
                if (data_tready) state_d = (state == DVAL) ? DRAIN : UDRAIN;
            end
            DRAIN: begin
                if (drain_ok) begin
                    cnt_inc  = 1'b1;
                    addr_inc = 1'b1;
                    set_done = last_addr;
                    state_d  = last_addr ? READY : FETCH;
                end
            end
            DELAY: begin
                if (delay_cnt == DELAY_LAST) begin
                    addr_inc = 1'b1;
                    set_done = last_addr;
                    state_d  = last_addr ? READY : FETCH;
                end
            end
            READY: begin
                // A restart takes priority over a pending user write.
                if (start) begin
                    restart = 1'b1;
                    state_d = FETCH;
                end else if (usr_valid) begin
                    usr_ready = 1'b1;
                    latch_usr = 1'b1;
                    state_d   = UCMD;
                end
            end
            UDRAIN: begin
                if (drain_ok) state_d = READY;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command fields are only driven while a command is offered.
    assign cmd_address        = cmd_valid ? DEV_ADDR : 7'h00;
    assign cmd_start          = cmd_valid;
    assign cmd_write_multiple = cmd_valid;
    assign cmd_stop           = cmd_valid;
    assign cmd_read           = 1'b0;
    assign cmd_write          = 1'b0;

    assign busy = (state != IDLE) && (state != READY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rom_addr  <= '0;
            cur_reg   <= 8'h00;
            cur_val   <= 8'h00;
            done      <= 1'b0;
            entry_cnt <= 8'h00;
            delay_cnt <= '0;
            drain_cnt <= 4'd0;
            busy_seen <= 1'b0;
        end else begin
            state <= state_d;

            if (restart) begin
                rom_addr  <= '0;
                done      <= 1'b0;
                entry_cnt <= 8'h00;
            end
            if (addr_inc)                        rom_addr  <= rom_addr + 1'b1;
            if (cnt_inc && entry_cnt != 8'hFF)   entry_cnt <= entry_cnt + 8'd1;
            if (set_done)                        done      <= 1'b1;

            if (latch_rom) begin
                cur_reg <= rom_data[15:8];
                cur_val <= rom_data[7:0];
            end else if (latch_usr) begin
                cur_reg <= usr_reg;
                cur_val <= usr_val;
            end

            // Counters restart on every fresh entry into their state.
            if (state == DELAY && state_d == DELAY) delay_cnt <= delay_cnt + 1'b1;
            else                                    delay_cnt <= '0;

            if ((state == DRAIN || state == UDRAIN) && state_d == state) begin
                if (drain_cnt != 4'd15) drain_cnt <= drain_cnt + 4'd1;
                busy_seen <= busy_seen | i2c_busy;
            end else begin
                drain_cnt <= 4'd0;
                busy_seen <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_sccb_init_sequencer.sv
`timescale 1ns/1ps
module tb_ov7670_sccb_init_sequencer;

    localparam int DLY = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        usr_valid;
    logic [7:0]  usr_reg, usr_val;
    logic        usr_ready;
    logic [6:0]  cmd_address;
    logic        cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  data_tdata;
    logic        data_tvalid, data_tready, data_tlast;
    logic        i2c_busy;
    logic        busy, done;
    logic [7:0]  entry_cnt;

    ov7670_sccb_init_sequencer #(.DEV_ADDR(7'h21), .ROM_AW(8), .DELAY_CYCLES(DLY)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .usr_valid(usr_valid), .usr_reg(usr_reg), .usr_val(usr_val), .usr_ready(usr_ready),
        .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read),
        .cmd_write(cmd_write), .cmd_write_multiple(cmd_write_multiple), .cmd_stop(cmd_stop),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .data_tdata(data_tdata), .data_tvalid(data_tvalid), .data_tready(data_tready),
        .data_tlast(data_tlast), .i2c_busy(i2c_busy),
        .busy(busy), .done(done), .entry_cnt(entry_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous table ROM.
    logic [15:0] rom [256];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Ready generation: 0 = tied high, 1 = random 0..7 cycle stalls, 2 = forced.
    int   bp_mode = 0;
    logic cmd_frc = 1'b1, dat_frc = 1'b1;
    logic cmd_rnd = 1'b1, dat_rnd = 1'b1;
    int   cmd_stall = 0, dat_stall = 0;
    always @(posedge clk) begin
        if (cmd_stall > 0) begin
            cmd_rnd   <= 1'b0;
            cmd_stall <= cmd_stall - 1;
        end else begin
            cmd_rnd <= 1'b1;
            if ($urandom_range(0, 2) == 0) cmd_stall <= $urandom_range(0, 7);
        end
        if (dat_stall > 0) begin
            dat_rnd   <= 1'b0;
            dat_stall <= dat_stall - 1;
        end else begin
            dat_rnd <= 1'b1;
            if ($urandom_range(0, 2) == 0) dat_stall <= $urandom_range(0, 7);
        end
    end
    always_comb begin
        cmd_ready   = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? cmd_rnd : cmd_frc;
        data_tready = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? dat_rnd : dat_frc;
    end

    // i2c_master busy model: rises 3 cycles after the last byte, high for 5 cycles.
    int   bcnt = 0;
    logic busy_en = 1'b1;
    always @(posedge clk) begin
        if (data_tvalid && data_tready && data_tlast) bcnt <= 8;
        else if (bcnt > 0)                            bcnt <= bcnt - 1;
    end
    always_comb i2c_busy = busy_en && (bcnt >= 1) && (bcnt <= 5);

    // Scoreboard: {tlast, byte} expected in order.
    logic [8:0] exp_q[$];
    int         cmd_hs_cyc[$];
    int         tlast_cyc[$];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic run_monitor();
        logic       pv_c, pr_c, pv_d, pr_d, plast;
        logic [7:0] pdat;
        logic [8:0] e;
        pv_c = 1'b0; pr_c = 1'b0; pv_d = 1'b0; pr_d = 1'b0; plast = 1'b0; pdat = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv_c = 1'b0;
                pv_d = 1'b0;
            end else begin
                if (pv_c && !pr_c) check("cmd_valid_hold", {31'd0, cmd_valid}, 32'd1);
                if (pv_d && !pr_d) begin
                    check("tvalid_hold", {31'd0, data_tvalid}, 32'd1);
                    check("tdata_hold", {23'd0, data_tlast, data_tdata}, {23'd0, plast, pdat});
                end
                if (cmd_valid)
                    check("cmd_fields", {20'd0, cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop},
                          {20'd0, 7'h21, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
                else
                    check("cmd_fields_idle", {20'd0, cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop}, 32'd0);
                if (cmd_valid && cmd_ready) cmd_hs_cyc.push_back(cyc);
                if (data_tvalid && data_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_unexpected_byte: got 0x%0h tlast=%0b, expected no byte", data_tdata, data_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        check("data_byte", {23'd0, data_tlast, data_tdata}, {23'd0, e});
                    end
                    if (data_tlast) tlast_cyc.push_back(cyc);
                end
                pv_c = cmd_valid;  pr_c = cmd_ready;
                pv_d = data_tvalid; pr_d = data_tready;
                pdat = data_tdata; plast = data_tlast;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_table4();
        exp_q.push_back({1'b0, 8'h12});
        exp_q.push_back({1'b1, 8'h80});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h00});
    endtask

    task automatic wait_done(input string nm, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done && !busy) break;
        end
        check(nm, {31'd0, done}, 32'd1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, gap, ups;
        logic [7:0] b;
        fork
            run_monitor();
        join_none

        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280; rom[1] = 16'hFFFE; rom[2] = 16'h1100; rom[3] = 16'hFFFF;
        reset = 1'b1; start = 1'b0; usr_valid = 1'b0; usr_reg = 8'h00; usr_val = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        usr_valid = 1'b1;
        usr_reg = 8'h33;
        usr_val = 8'h44;
        @(negedge clk);
        check("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
        check("rst_valids", {30'd0, cmd_valid, data_tvalid}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_entry_cnt", {24'd0, entry_cnt}, 32'd0);
        check("idle_usr_ready", {31'd0, usr_ready}, 32'd0);
        tick();
        usr_valid = 1'b0;

        // Table walk with delay marker, readies tied high.
        push_table4();
        lat = 0;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            #1 start = 1'b0;
            @(negedge clk);
            if (cmd_valid) break;
        end
        check("start_to_cmd_latency", lat, 32'd3);
        wait_done("tableA_done", 2000);
        check("tableA_entry_cnt", {24'd0, entry_cnt}, 32'd2);
        check("tableA_rom_addr", {24'd0, rom_addr}, 32'd3);
        check("tableA_sb_empty", exp_q.size(), 32'd0);
        check("tableA_cmd_count", cmd_hs_cyc.size(), 32'd2);
        gap = (cmd_hs_cyc.size() > 1 && tlast_cyc.size() > 0) ? cmd_hs_cyc[1] - tlast_cyc[0] : 0;
        check("delay_gap_ge_50", {31'd0, gap >= DLY}, 32'd1);
        check("delay_gap_le_80", {31'd0, gap <= 80}, 32'd1);

        // Same table under random backpressure, restarted from READY.
        bp_mode = 1;
        push_table4();
        pulse_start();
        wait_done("tableB_done", 4000);
        check("tableB_entry_cnt", {24'd0, entry_cnt}, 32'd2);
        check("tableB_sb_empty", exp_q.size(), 32'd0);
        bp_mode = 0;

        // User single-register write after done.
        exp_q.push_back({1'b0, 8'h40});
        exp_q.push_back({1'b1, 8'hD0});
        usr_reg = 8'h40;
        usr_val = 8'hD0;
        usr_valid = 1'b1;
        ups = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (usr_ready) ups++;
            tick();
            if (ups != 0) usr_valid = 1'b0;
        end
        usr_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("usr_ready_pulse_cycles", ups, 32'd1);
        check("usr_back_ready", {31'd0, busy}, 32'd0);
        check("usr_entry_cnt", {24'd0, entry_cnt}, 32'd2);
        check("usr_done_sticky", {31'd0, done}, 32'd1);
        check("usr_sb_empty", exp_q.size(), 32'd0);
        tick();

        // Start and user request in the same READY cycle: start wins.
        push_table4();
        start = 1'b1;
        usr_valid = 1'b1;
        usr_reg = 8'h55;
        usr_val = 8'h66;
        @(negedge clk);
        check("start_vs_usr_ready", {31'd0, usr_ready}, 32'd0);
        tick();
        start = 1'b0;
        usr_valid = 1'b0;
        @(negedge clk);
        check("restart_busy_done", {30'd0, busy, done}, 32'b10);
        wait_done("tableC_done", 2000);
        check("tableC_entry_cnt", {24'd0, entry_cnt}, 32'd2);
        check("tableC_sb_empty", exp_q.size(), 32'd0);

        // Reset while the value byte is stalled in DVAL.
        bp_mode = 2;
        cmd_frc = 1'b1;
        dat_frc = 1'b0;
        exp_q.push_back({1'b0, 8'h12});
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (data_tvalid) break;
        end
        tick();
        dat_frc = 1'b1;
        tick();
        dat_frc = 1'b0;
        @(negedge clk);
        check("stalled_in_dval", {30'd0, data_tvalid, data_tlast}, 32'b11);
        tick();
        reset = 1'b1;
        #1;
        check("rstmid_valids", {30'd0, cmd_valid, data_tvalid}, 32'd0);
        check("rstmid_busy_done", {30'd0, busy, done}, 32'd0);
        check("rstmid_rom_addr", {24'd0, rom_addr}, 32'd0);
        check("rstmid_sb_empty", exp_q.size(), 32'd0);
        tick();
        reset = 1'b0;
        bp_mode = 0;
        tick();
        push_table4();
        pulse_start();
        wait_done("replay_done", 2000);
        check("replay_entry_cnt", {24'd0, entry_cnt}, 32'd2);
        check("replay_sb_empty", exp_q.size(), 32'd0);

        // Full 256-entry table without end marker; busy never rises, so DRAIN times out.
        busy_en = 1'b0;
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            rom[i] = {b, ~b};
            exp_q.push_back({1'b0, b});
            exp_q.push_back({1'b1, ~b});
        end
        pulse_start();
        wait_done("wrap_done", 12000);
        check("wrap_entry_cnt", {24'd0, entry_cnt}, 32'd255);
        check("wrap_sb_empty", exp_q.size(), 32'd0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
